// File: rtl/io_cfg_sequencer.sv
// rtl/io_cfg_sequencer.sv - boot-time IO pad register init sequencer with Wishbone passthrough
//
// Purpose: after reset, walks INIT_TABLE and writes each entry to the IO
// register file over the downstream Wishbone port. When VERIFY is set, it
// reads each entry back and compares it. It then hands the port to the CPU
// as a transparent combinational passthrough.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             single-cycle pulse, reruns the table from PASS
//   cpu_*_i / cpu_*_o CPU-side Wishbone slave port (stalled until PASS)
//   m_*_o / m_*_i     downstream Wishbone master port to the register file
//   busy, done, error sequence status; err_index = failing table entry

module io_cfg_sequencer #(
   parameter int                        NUM_ENTRIES = 2,
   parameter logic [NUM_ENTRIES*52-1:0] INIT_TABLE  = {4'hF, 16'h0004, 32'h0000_0F00,
                                                       4'hF, 16'h0000, 32'h0000_00FF},
   parameter bit                        VERIFY      = 1'b1,
   parameter logic [31:0]               VERIFY_MASK = 32'h003F_FFFF,
   parameter int                        TIMEOUT     = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] cpu_adr_i,
   input  logic [31:0] cpu_dat_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic        cpu_we_i,
   input  logic        cpu_stb_i,
   input  logic        cpu_cyc_i,
   output logic [31:0] cpu_dat_o,
   output logic        cpu_ack_o,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_stb_o,
   output logic        m_cyc_o,
   input  logic [31:0] m_dat_i,
   input  logic        m_ack_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [3:0]  err_index
);

   localparam logic [2:0] ST_BOOT  = 3'd0;
   localparam logic [2:0] ST_WR    = 3'd1;
   localparam logic [2:0] ST_GAP_W = 3'd2;
   localparam logic [2:0] ST_RD    = 3'd3;
   localparam logic [2:0] ST_GAP_R = 3'd4;
   localparam logic [2:0] ST_PASS  = 3'd5;

   localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);
   // The abort fires on the edge that would take the timer to TIMEOUT, so
   // m_cyc_o is high for exactly TIMEOUT cycles.
   localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

   logic [2:0]  state;
   logic [3:0]  idx;
   logic [3:0]  timer;
   logic        pending;

   logic [51:0] entry;
   logic [3:0]  ent_sel;
   logic [15:0] ent_adr;
   logic [31:0] ent_dat;
   logic [31:0] byte_mask;
   logic        rd_mismatch;
   logic        last_entry;
   logic        rerun;
   logic        timed_out;

   // Constant-index unrolled mux keeps the table select in range for any idx.
   always_comb begin
      entry = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (idx == 4'(i)) entry = INIT_TABLE[52*i +: 52];
      end
   end

   assign ent_sel     = entry[51:48];
   assign ent_adr     = entry[47:32];
   assign ent_dat     = entry[31:0];
   assign byte_mask   = {{8{ent_sel[3]}}, {8{ent_sel[2]}}, {8{ent_sel[1]}}, {8{ent_sel[0]}}};
   assign rd_mismatch = |((m_dat_i ^ ent_dat) & VERIFY_MASK & byte_mask);
   assign last_entry  = (idx == LAST_IDX);
   assign timed_out   = (timer == TMO_LAST);
   // A start seen during a CPU cycle is held and replayed once the CPU lets go.
   assign rerun       = (start | pending) & ~cpu_cyc_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_BOOT;
         idx       <= 4'd0;
         timer     <= 4'd0;
         pending   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_index <= 4'd0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_WR;
               busy  <= 1'b1;
               timer <= 4'd0;
            end
            ST_WR: begin
               if (m_ack_i) begin
                  state <= ST_GAP_W;
               end else if (timed_out) begin
                  state     <= ST_PASS;
                  error     <= 1'b1;
                  err_index <= idx;
                  done      <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  timer <= timer + 4'd1;
               end
            end
            ST_GAP_W: begin
               // The slave's registered ack lingers into this cycle; ignore it.
               if (VERIFY) begin
                  state <= ST_RD;
                  timer <= 4'd0;
               end else if (last_entry) begin
                  state <= ST_PASS;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= ST_WR;
                  timer <= 4'd0;
               end
            end
            ST_RD: begin
               if (m_ack_i) begin
                  if (rd_mismatch) begin
                     state     <= ST_PASS;
                     error     <= 1'b1;
                     err_index <= idx;
                     done      <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     state <= ST_GAP_R;
                  end
               end else if (timed_out) begin
                  state     <= ST_PASS;
                  error     <= 1'b1;
                  err_index <= idx;
                  done      <= 1'b0;
                  busy      <= 1'b0;
               end else begin
                  timer <= timer + 4'd1;
               end
            end
            ST_GAP_R: begin
               if (last_entry) begin
                  state <= ST_PASS;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  idx   <= idx + 4'd1;
                  state <= ST_WR;
                  timer <= 4'd0;
               end
            end
            ST_PASS: begin
               if (rerun) begin
                  pending   <= 1'b0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  err_index <= 4'd0;
                  idx       <= 4'd0;
                  timer     <= 4'd0;
                  busy      <= 1'b1;
                  state     <= ST_WR;
               end else if (start) begin
                  pending <= 1'b1;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end

   always_comb begin
      m_adr_o   = 32'h0;
      m_dat_o   = 32'h0;
      m_sel_o   = 4'h0;
      m_we_o    = 1'b0;
      m_stb_o   = 1'b0;
      m_cyc_o   = 1'b0;
      cpu_ack_o = 1'b0;
      cpu_dat_o = 32'h0;
      case (state)
         ST_WR: begin
            m_adr_o = {16'h0, ent_adr};
            m_dat_o = ent_dat;
            m_sel_o = ent_sel;
            m_we_o  = 1'b1;
            m_stb_o = 1'b1;
            m_cyc_o = 1'b1;
         end
         ST_RD: begin
            m_adr_o = {16'h0, ent_adr};
            m_dat_o = ent_dat;
            m_sel_o = ent_sel;
            m_stb_o = 1'b1;
            m_cyc_o = 1'b1;
         end
         ST_PASS: begin
            m_adr_o   = cpu_adr_i;
            m_dat_o   = cpu_dat_i;
            m_sel_o   = cpu_sel_i;
            m_we_o    = cpu_we_i;
            m_stb_o   = cpu_stb_i;
            m_cyc_o   = cpu_cyc_i;
            cpu_ack_o = m_ack_i;
            cpu_dat_o = m_dat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_io_cfg_sequencer.sv
// tb/tb_io_cfg_sequencer.sv - directed bench for io_cfg_sequencer with 1-wait register file model

module tb_io_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] cpu_adr_i = '0;
   logic [31:0] cpu_dat_i = '0;
   logic [3:0]  cpu_sel_i = '0;
   logic        cpu_we_i = 1'b0;
   logic        cpu_stb_i = 1'b0;
   logic        cpu_cyc_i = 1'b0;
   logic [31:0] cpu_dat_o;
   logic        cpu_ack_o;
   logic [31:0] m_adr_o;
   logic [31:0] m_dat_o;
   logic [3:0]  m_sel_o;
   logic        m_we_o;
   logic        m_stb_o;
   logic        m_cyc_o;
   logic [31:0] m_dat_i;
   logic        m_ack_i;
   logic        busy;
   logic        done;
   logic        error;
   logic [3:0]  err_index;

   int vectors = 0;
   int miscompares = 0;

   // register file model controls
   logic        no_ack = 1'b0;
   logic        clr_regs = 1'b0;
   logic        stuck_all = 1'b0;
   logic [31:0] stuck_adr = '0;
   logic [31:0] stuck_or = '0;
   logic [31:0] regs [0:1];
   logic        s_ack = 1'b0;
   logic [31:0] s_rdat = '0;

   assign m_ack_i = s_ack;
   assign m_dat_i = s_rdat;

   io_cfg_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_sel_i(cpu_sel_i),
      .cpu_we_i(cpu_we_i), .cpu_stb_i(cpu_stb_i), .cpu_cyc_i(cpu_cyc_i),
      .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
      .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
      .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
      .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   // 1-wait slave: ack registered from cyc&stb (lingers one cycle after cyc drops)
   always @(posedge clk) begin
      if (clr_regs) begin
         regs[0] <= '0;
         regs[1] <= '0;
      end
      s_ack <= no_ack ? 1'b0 : (m_cyc_o & m_stb_o);
      if (m_cyc_o && m_stb_o && !s_ack && !no_ack && !clr_regs) begin
         if (m_we_o) begin
            for (int b = 0; b < 4; b++)
               if (m_sel_o[b]) regs[m_adr_o[2]][8*b +: 8] <= m_dat_o[8*b +: 8];
         end else begin
            s_rdat <= regs[m_adr_o[2]] | ((stuck_all || m_adr_o == stuck_adr) ? stuck_or : 32'h0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // leaves rst low #1 after an edge; the next posedge is edge 1
   task automatic do_reset;
      rst = 1'b1; start = 1'b0;
      cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      cpu_adr_i = '0; cpu_dat_i = '0; cpu_sel_i = '0;
      clr_regs = 1'b1;
      repeat (3) tick;
      clr_regs = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 32'h4; cpu_dat_i = 32'h55; cpu_sel_i = 4'hF;
      repeat (2) tick;
      vectors++; if (m_cyc_o !== 1'b0) begin miscompares++; $display("FAIL reset_m_cyc got %0h exp 0", m_cyc_o); end
      vectors++; if (m_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_m_we got %0h exp 0", m_we_o); end
      vectors++; if (m_adr_o !== 32'h0) begin miscompares++; $display("FAIL reset_m_adr got %0h exp 0", m_adr_o); end
      vectors++; if (m_dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_m_dat got %0h exp 0", m_dat_o); end
      vectors++; if (cpu_ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ack got %0h exp 0", cpu_ack_o); end
      vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %0b exp 000", {busy, done, error}); end
      vectors++; if (err_index !== 4'h0) begin miscompares++; $display("FAIL reset_err_index got %0h exp 0", err_index); end
      cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
   endtask

   task automatic test_default_seq;
      logic [12:0] cyc_pat, we_pat;
      logic [31:0] adr_e1, dat_e1, adr_e10;
      logic        busy_e1, done_e12;
      do_reset;
      for (int k = 1; k <= 13; k++) begin
         tick;
         cyc_pat[k-1] = m_cyc_o;
         we_pat[k-1]  = m_we_o;
         if (k == 1) begin adr_e1 = m_adr_o; dat_e1 = m_dat_o; busy_e1 = busy; end
         if (k == 10) adr_e10 = m_adr_o;
         if (k == 12) done_e12 = done;
      end
      vectors++; if (cyc_pat !== 13'h06DB) begin miscompares++; $display("FAIL seq_cyc_pattern got %0h exp 6db", cyc_pat); end
      vectors++; if (we_pat !== 13'h00C3) begin miscompares++; $display("FAIL seq_we_pattern got %0h exp c3", we_pat); end
      vectors++; if (adr_e1 !== 32'h0) begin miscompares++; $display("FAIL seq_adr_entry0 got %0h exp 0", adr_e1); end
      vectors++; if (dat_e1 !== 32'hFF) begin miscompares++; $display("FAIL seq_dat_entry0 got %0h exp ff", dat_e1); end
      vectors++; if (busy_e1 !== 1'b1) begin miscompares++; $display("FAIL seq_busy_edge1 got %0h exp 1", busy_e1); end
      vectors++; if (adr_e10 !== 32'h4) begin miscompares++; $display("FAIL seq_adr_rd_entry1 got %0h exp 4", adr_e10); end
      vectors++; if (done_e12 !== 1'b0) begin miscompares++; $display("FAIL seq_done_edge12 got %0h exp 0", done_e12); end
      vectors++; if ({busy, done, error} !== 3'b010) begin miscompares++; $display("FAIL seq_flags_edge13 got %0b exp 010", {busy, done, error}); end
      vectors++; if (regs[0] !== 32'hFF) begin miscompares++; $display("FAIL seq_oe_reg got %0h exp ff", regs[0]); end
      vectors++; if (regs[1] !== 32'hF00) begin miscompares++; $display("FAIL seq_fn_reg got %0h exp f00", regs[1]); end
   endtask

   task automatic test_cpu_stall;
      int early_acks = 0;
      int n = 0;
      do_reset;
      tick;
      cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 32'h0; cpu_dat_i = 32'h3; cpu_sel_i = 4'hF;
      for (int k = 2; k <= 13; k++) begin
         tick;
         if (cpu_ack_o) early_acks++;
      end
      vectors++; if (early_acks !== 0) begin miscompares++; $display("FAIL stall_early_acks got %0d exp 0", early_acks); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %0h exp 1", done); end
      while (!cpu_ack_o && n < 5) begin tick; n++; end
      vectors++; if (cpu_ack_o !== 1'b1) begin miscompares++; $display("FAIL stall_passthru_ack got %0h exp 1", cpu_ack_o); end
      cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0; cpu_we_i = 1'b0;
      tick;
      vectors++; if (regs[0] !== 32'h3) begin miscompares++; $display("FAIL stall_oe_reg got %0h exp 3", regs[0]); end
   endtask

   task automatic test_verify_mask;
      stuck_all = 1'b1; stuck_or = 32'h0080_0000;
      do_reset;
      repeat (13) tick;
      vectors++; if ({done, error} !== 2'b10) begin miscompares++; $display("FAIL mask_bit23 got done,error=%0b exp 10", {done, error}); end
      stuck_all = 1'b0; stuck_or = '0;
   endtask

   task automatic test_verify_fail;
      stuck_adr = 32'h4; stuck_or = 32'h1;
      do_reset;
      repeat (11) tick;
      vectors++; if ({busy, error} !== 2'b10) begin miscompares++; $display("FAIL vfail_pre_abort got busy,error=%0b exp 10", {busy, error}); end
      tick;
      vectors++; if ({busy, done, error} !== 3'b001) begin miscompares++; $display("FAIL vfail_flags got %0b exp 001", {busy, done, error}); end
      vectors++; if (err_index !== 4'd1) begin miscompares++; $display("FAIL vfail_err_index got %0h exp 1", err_index); end
      stuck_or = '0; stuck_adr = '0;
   endtask

   task automatic test_timeout;
      int high = 0;
      no_ack = 1'b1;
      do_reset;
      for (int k = 0; k < 40; k++) begin
         tick;
         if (m_cyc_o) high++;
      end
      vectors++; if (high !== 15) begin miscompares++; $display("FAIL tmo_cyc_cycles got %0d exp 15", high); end
      vectors++; if ({busy, done, error} !== 3'b001) begin miscompares++; $display("FAIL tmo_flags got %0b exp 001", {busy, done, error}); end
      vectors++; if (err_index !== 4'd0) begin miscompares++; $display("FAIL tmo_err_index got %0h exp 0", err_index); end
      cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
      #1;
      vectors++; if (m_cyc_o !== 1'b1) begin miscompares++; $display("FAIL tmo_pass_mux got %0h exp 1", m_cyc_o); end
      cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
      no_ack = 1'b0;
   endtask

   task automatic test_start_during_read;
      do_reset;
      repeat (13) tick;
      cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 32'h0; cpu_sel_i = 4'hF;
      start = 1'b1;
      tick;
      start = 1'b0;
      vectors++; if (cpu_ack_o !== 1'b1) begin miscompares++; $display("FAIL rerun_cpu_ack got %0h exp 1", cpu_ack_o); end
      vectors++; if (cpu_dat_o !== 32'hFF) begin miscompares++; $display("FAIL rerun_cpu_rdat got %0h exp ff", cpu_dat_o); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rerun_done_held got %0h exp 1", done); end
      cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
      tick;
      vectors++; if ({busy, done, m_cyc_o} !== 3'b101) begin miscompares++; $display("FAIL rerun_begin got busy,done,cyc=%0b exp 101", {busy, done, m_cyc_o}); end
      repeat (11) tick;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rerun_done_early got %0h exp 0", done); end
      tick;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rerun_done_12 got %0h exp 1", done); end
   endtask

   task automatic test_back_to_back;
      // PASS with CPU idle: start begins at once; a start mid-run is ignored
      start = 1'b1;
      tick;
      start = 1'b0;
      vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL b2b_begin got busy,done=%0b exp 10", {busy, done}); end
      repeat (4) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (6) tick;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_early got %0h exp 0", done); end
      tick;
      vectors++; if ({busy, done, error} !== 3'b010) begin miscompares++; $display("FAIL b2b_done_12 got %0b exp 010", {busy, done, error}); end
   endtask

   task automatic test_rst_mid;
      do_reset;
      repeat (10) tick;
      vectors++; if ({m_cyc_o, m_we_o, m_adr_o} !== {2'b10, 32'h4}) begin miscompares++; $display("FAIL rstmid_in_rd got cyc,we,adr=%0b,%0b,%0h exp 1,0,4", m_cyc_o, m_we_o, m_adr_o); end
      rst = 1'b1;
      tick;
      vectors++; if (m_cyc_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_cyc_drop got %0h exp 0", m_cyc_o); end
      vectors++; if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL rstmid_flags got %0b exp 000", {busy, done, error}); end
      rst = 1'b0;
      tick;
      vectors++; if ({m_cyc_o, m_we_o, m_adr_o} !== {2'b11, 32'h0}) begin miscompares++; $display("FAIL rstmid_restart got cyc,we,adr=%0b,%0b,%0h exp 1,1,0", m_cyc_o, m_we_o, m_adr_o); end
      repeat (11) tick;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done_early got %0h exp 0", done); end
      tick;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rstmid_done got %0h exp 1", done); end
   endtask

   initial begin
      test_reset;
      test_default_seq;
      test_cpu_stall;
      test_verify_mask;
      test_verify_fail;
      test_timeout;
      test_start_during_read;
      test_back_to_back;
      test_rst_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/io_cfg_sequencer.md
Name: io_cfg_sequencer

Overview:
- Boot-time configuration controller and bus owner for the IO pad register file (GPIO direction / pad function registers).
- After reset, walks a parameterised init table, issuing Wishbone writes with optional read-back verify.
- On completion, hands the downstream Wishbone port to the CPU as a transparent passthrough.
- Sits between the CPU-side Wishbone interconnect and the IO register file.

Parameters:
- NUM_ENTRIES, 2: number of init table entries (1..16).
- INIT_TABLE, {4'hF,16'h0004,32'h0000_0F00, 4'hF,16'h0000,32'h0000_00FF}: flattened NUM_ENTRIES*52 bits. Entry i = bits [52*i+51:52*i] = {sel[3:0], adr[15:0], dat[31:0]}. Entry 0 is the lowest bits (oe write first).
- VERIFY, 1: 1 = read back and compare each entry after writing it.
- VERIFY_MASK, 32'h003F_FFFF: implemented-bit mask applied in the compare.
- TIMEOUT, 15: maximum cycles m_cyc_o may stay high without m_ack_i.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  single-cycle pulse; rerun the table from the PASS state
- cpu_adr_i  in  32  CPU address
- cpu_dat_i  in  32  CPU write data
- cpu_sel_i  in  4  CPU byte select
- cpu_we_i  in  1  CPU write enable
- cpu_stb_i  in  1  CPU strobe
- cpu_cyc_i  in  1  CPU cycle
- cpu_dat_o  out  32  CPU read data
- cpu_ack_o  out  1  CPU acknowledge
- m_adr_o  out  32  downstream address
- m_dat_o  out  32  downstream write data
- m_sel_o  out  4  downstream byte select
- m_we_o  out  1  downstream write enable
- m_stb_o  out  1  downstream strobe
- m_cyc_o  out  1  downstream cycle
- m_dat_i  in  32  downstream read data
- m_ack_i  in  1  downstream acknowledge
- busy  out  1  sequence in progress
- done  out  1  last sequence completed without error
- error  out  1  last sequence aborted (verify mismatch or timeout)
- err_index  out  4  index of the failing entry

Behaviour:
- Reset values: all m_* = 0; cpu_ack_o = 0; cpu_dat_o = 0; busy = done = error = 0; err_index = 0. State = BOOT, idx = 0.
- States: BOOT, WR, GAP_W, RD, GAP_R, PASS.
- BOOT: one cycle, then WR; busy = 1 from that edge onward.
- WR: m_cyc_o = m_stb_o = m_we_o = 1; m_adr_o = {16'h0, adr[idx]}; m_dat_o = dat[idx]; m_sel_o = sel[idx].
  - m_ack_i = 1 -> GAP_W.
  - timer reaches TIMEOUT -> abort.
- GAP_W: exactly one cycle with m_cyc_o = m_stb_o = 0. m_ack_i is ignored here (the slave ack is registered from cyc and lingers one cycle).
  - Next state is RD if VERIFY = 1, else the next entry.
- RD: m_cyc_o = m_stb_o = 1, m_we_o = 0, same address. On m_ack_i, sample m_dat_i. Compare (m_dat_i ^ dat[idx]) & VERIFY_MASK & bytemask(sel[idx]).
  - Nonzero -> abort.
  - Zero -> GAP_R.
  - Timeout -> abort.
- GAP_R: one idle cycle, ack ignored, then next entry.
- Next entry: idx++ -> WR. After idx = NUM_ENTRIES-1 -> PASS with done = 1, busy = 0.
- Abort: error = 1, err_index = idx, done = 0, busy = 0, drop cyc/stb in the same edge -> PASS. Remaining entries are skipped.
- Timer: 4-bit, cleared on entering WR/RD, increments each cycle while cyc is high.
- PASS: combinational mux.
  - m_adr_o, m_dat_o, m_sel_o, m_we_o, m_stb_o, m_cyc_o = cpu_*.
  - cpu_ack_o = m_ack_i; cpu_dat_o = m_dat_i.
- Outside PASS: cpu_ack_o = 0, cpu_dat_o = 0; CPU cycles stall (classic Wishbone, no retry/error).
- start in PASS:
  - If cpu_cyc_i = 0: clear done/error/err_index, idx = 0, go to WR next cycle.
  - If cpu_cyc_i = 1: latch a pending flag. Rerun on the first cycle with cpu_cyc_i = 0; the CPU cycle completes first.
  - start outside PASS is ignored.
- rst mid-sequence: immediate return to reset values. m_cyc_o drops the following cycle; no partial-entry resume.
- Timing with a 1-wait slave (ack one edge after cyc):
  - 6 cycles per entry with VERIFY = 1; 3 cycles per entry with VERIFY = 0.
  - Default table: done rises after the 13th rising edge following rst deassertion.

Test Plan:
- Default params, 1-wait regfile model, release rst -> writes adr 0x0 dat 0xFF, then reads back. Then writes adr 0x4 dat 0xF00 and reads back. done = 1 after edge 13; regfile oe = 0x0000FF, fn = 0x000F00; m_cyc_o low in every gap cycle.
- CPU asserts cpu_cyc_i/stb/we to adr 0x0 dat 0x3 at edge 2 -> cpu_ack_o stays 0 until PASS. Then ack arrives via passthrough; final oe = 0x000003.
- Slave model forces bit 23 stuck-at-1 on reads -> masked by VERIFY_MASK, done = 1. Stuck bit 0 at 1 on entry 1 instead -> error = 1, err_index = 1, done = 0.
- Slave never acks -> m_cyc_o high exactly 15 cycles in WR of entry 0, then error = 1, err_index = 0, state PASS.
- In PASS, pulse start while a CPU read is in progress -> the CPU read completes with correct data. Rerun begins the cycle after cpu_cyc_i falls; done clears then re-asserts 12 cycles later.
- Assert rst during RD of entry 1 -> next cycle m_cyc_o = 0, all flags 0. After release, the full sequence repeats from entry 0.
